prefetch_ctrl: RTL and testbench
================================

// Module: prefetch_ctrl
// PURPOSE
//  Sequencer for the prefetch fetch FIFO. Walks the word-aligned fetch address,
//  issues MMU translation then icache requests one word at a time, and tracks
//  FIFO occupancy in halfwords plus the read-side halfword offset.
//  Handles redirects: flush, discard of any in-flight icache response, restart.
//  Sits between IF (redirect/consume) and the MMU/icache request ports.
// PARAMETERS
//  FIFO_WORDS  2             depth of fetch FIFO in 32-bit words (>=2)
//  RESET_PC    32'h8000_0000 fetch start address after reset
//  CW          $clog2(2*FIFO_WORDS+1)  width of halfword count (localparam)
// PORTS
//  clk             in   1   clock
//  reset           in   1   asynchronous, active-high reset
//  redirect_i      in   1   flush FIFO, restart fetch at redirect_pc_i
//  redirect_pc_i   in   32  new PC (halfword aligned, bit0 ignored)
//  consume_i       in   1   IF takes one instruction this cycle
//  consume_comp_i  in   1   consumed instruction is 16-bit (else 32-bit)
//  hw_count_o      out  CW  valid halfwords available to IF
//  rd_hw_off_o     out  1   read pointer sits on upper halfword (misaligned)
//  buf_wr_o        out  1   push icache word into fetch FIFO this cycle
//  buf_clear_o     out  1   clear fetch FIFO contents this cycle
//  mmu_req_o       out  1   translation request
//  fetch_vaddr_o   out  32  word-aligned fetch VA ([1:0]=0)
//  mmu_hit_i       in   1   translation hit this cycle
//  mmu_fault_i     in   1   translation fault this cycle
//  icache_req_o    out  1   icache request (held until ack)
//  icache_ack_i    in   1   icache data valid
//  fault_o         out  1   fetch fault pending
// BEHAVIOUR
//  Reset: state IDLE; fetch_vaddr_o=RESET_PC&~3; rd_hw_off_o=RESET_PC[1];
//   skip_lo=RESET_PC[1]; hw_count_o=0; all other outputs 0.
//  FSM states IDLE, XLATE, CACHE, DRAIN, FAULT; one outstanding request max.
//  IDLE: if hw_count_o <= 2*FIFO_WORDS-2 -> XLATE, else stay.
//  XLATE: mmu_req_o=1; icache_req_o=mmu_hit_i (same cycle);
//   hit -> CACHE; fault (fault wins over hit) -> FAULT.
//  CACHE: icache_req_o=1 until icache_ack_i; on ack buf_wr_o=1,
//   fetch_vaddr_o+=4 (wraps mod 2^32), skip_lo cleared, -> IDLE.
//  DRAIN: icache_req_o=1 until ack; ack discarded (buf_wr_o=0) -> IDLE.
//  FAULT: fault_o=1, no requests; exits only on redirect.
//  Redirect (any state, highest priority): buf_clear_o=1 same cycle;
//   hw_count_o<=0; fetch_vaddr_o<=pc&~3; rd_hw_off_o<=pc[1]; skip_lo<=pc[1];
//   next state DRAIN if in CACHE without ack or already in DRAIN without ack,
//   else IDLE. Ack coincident with redirect is discarded. Consume ignored.
//  Push adds 2 halfwords, or 1 if skip_lo set (lower half of first word dropped).
//  Consume legal only if hw_count_o >= (comp ? 1 : 2); illegal consume ignored.
//   comp: count-=1, rd_hw_off_o toggles; 32-bit: count-=2, offset unchanged.
//  Simultaneous push+consume: count updates by net sum in one cycle.
//  Space check uses registered count; never exceeds 2*FIFO_WORDS.
//  FAULT: remaining halfwords stay consumable; hw_count_o still decrements.
//  Latency: IDLE->push minimum 3 cycles (IDLE, XLATE hit, CACHE ack).
// TESTING
//  1 Release reset, hit in 1st XLATE cycle, ack 2nd CACHE cycle -> buf_wr_o 1 cycle,
//    hw_count_o=2, fetch_vaddr_o=0x8000_0004; no consume -> stalls at count 4.
//  2 Redirect to 0x8000_0102 -> buf_clear_o=1, fetch 0x8000_0100, after ack
//    hw_count_o=1, rd_hw_off_o=1; consume comp -> count 0, offset 0.
//  3 Redirect while CACHE waits, ack 2 cycles later -> buf_wr_o stays 0,
//    count 0, then new XLATE at redirect address; ack+redirect same cycle discarded.
//  4 Count 2, 32-bit consume + push same cycle -> count 2; count 1, 32-bit
//    consume -> ignored, count 1.
//  5 mmu_fault_i in XLATE with 2 halfwords buffered -> fault_o=1, mmu_req_o=0,
//    consume drains to 0; redirect -> fault_o=0, fetch resumes.
//  6 Reset asserted mid-CACHE -> all outputs to reset values immediately (async).

Source files
------------

// File: rtl/prefetch_ctrl.sv
// Prefetch sequencer: walks word-aligned fetch addresses through MMU then icache,
// and tracks fetch-FIFO halfword occupancy plus the read-side halfword offset.
module prefetch_ctrl #(
    parameter int          FIFO_WORDS = 2,
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    localparam int         CW         = $clog2(2*FIFO_WORDS+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    input  logic          consume_i,
    input  logic          consume_comp_i,
    output logic [CW-1:0] hw_count_o,
    output logic          rd_hw_off_o,
    output logic          buf_wr_o,
    output logic          buf_clear_o,
    output logic          mmu_req_o,
    output logic [31:0]   fetch_vaddr_o,
    input  logic          mmu_hit_i,
    input  logic          mmu_fault_i,
    output logic          icache_req_o,
    input  logic          icache_ack_i,
    output logic          fault_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XLATE,
        S_CACHE,
        S_DRAIN,
        S_FAULT
    } state_t;

    localparam logic [CW-1:0] SPACE_LIMIT = CW'(2*FIFO_WORDS-2);
    localparam logic [31:0]   RESET_VADDR = {RESET_PC[31:2], 2'b00};

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_hw_count;
    logic [CW-1:0]  w_hw_count_next;
    logic [31:0]    r_fetch_vaddr;
    logic           r_rd_hw_off;
    logic           r_skip_lo;

    logic           w_push;
    logic [CW-1:0]  w_push_amt;
    logic [CW-1:0]  w_cons_amt;
    logic           w_cons_ok;
    logic           w_mmu_req;
    logic           w_icache_req;
    logic           w_fault;
    logic           w_unused_pc0;

    assign w_unused_pc0 = redirect_pc_i[0];

    // A response arriving in the same cycle as a redirect belongs to the old stream.
    assign w_push     = (r_state == S_CACHE) && icache_ack_i && !redirect_i;
    assign w_push_amt = r_skip_lo ? CW'(1) : CW'(2);
    assign w_cons_amt = consume_comp_i ? CW'(1) : CW'(2);
    assign w_cons_ok  = consume_i && !redirect_i && (r_hw_count >= w_cons_amt);

    always_comb begin
        w_hw_count_next = r_hw_count;
        if (redirect_i) begin
            w_hw_count_next = '0;
        end else begin
            w_hw_count_next = r_hw_count
                            + (w_push    ? w_push_amt : CW'(0))
                            - (w_cons_ok ? w_cons_amt : CW'(0));
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mmu_req    = 1'b0;
        w_icache_req = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_hw_count <= SPACE_LIMIT) begin
                    w_state_next = S_XLATE;
                end
            end
            S_XLATE: begin
                w_mmu_req = 1'b1;
                // No icache request is launched if the stream is being redirected away.
                w_icache_req = mmu_hit_i && !mmu_fault_i && !redirect_i;
                if (mmu_fault_i) begin
                    w_state_next = S_FAULT;
                end else if (mmu_hit_i) begin
                    w_state_next = S_CACHE;
                end
            end
            S_CACHE: begin
                w_icache_req = 1'b1;
                if (icache_ack_i) begin
                    w_state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_icache_req = 1'b1;
                if (icache_ack_i) begin
                    w_state_next = S_IDLE;
                end
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // An outstanding icache request must still be retired before fetching anew.
        if (redirect_i) begin
            if (((r_state == S_CACHE) || (r_state == S_DRAIN)) && !icache_ack_i) begin
                w_state_next = S_DRAIN;
            end else begin
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_hw_count    <= '0;
            r_fetch_vaddr <= RESET_VADDR;
            r_rd_hw_off   <= RESET_PC[1];
            r_skip_lo     <= RESET_PC[1];
        end else begin
            r_state    <= w_state_next;
            r_hw_count <= w_hw_count_next;
            if (redirect_i) begin
                r_fetch_vaddr <= {redirect_pc_i[31:2], 2'b00};
                r_rd_hw_off   <= redirect_pc_i[1];
                r_skip_lo     <= redirect_pc_i[1];
            end else begin
                if (w_push) begin
                    r_fetch_vaddr <= r_fetch_vaddr + 32'd4;
                    r_skip_lo     <= 1'b0;
                end
                if (w_cons_ok && consume_comp_i) begin
                    r_rd_hw_off <= ~r_rd_hw_off;
                end
            end
        end
    end

    assign hw_count_o    = r_hw_count;
    assign rd_hw_off_o   = r_rd_hw_off;
    assign fetch_vaddr_o = r_fetch_vaddr;
    assign buf_wr_o      = w_push;
    assign buf_clear_o   = redirect_i;
    assign mmu_req_o     = w_mmu_req;
    assign icache_req_o  = w_icache_req;
    assign fault_o       = w_fault;

endmodule

// File: tb/tb_prefetch_ctrl.sv
// Scenario bench for prefetch_ctrl: expected pushes are queued when the ack is
// driven and checked when buf_wr_o fires; counts and offsets come from a bench model.
module tb_prefetch_ctrl;

    localparam int FW = 2;
    localparam int CW = $clog2(2*FW+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          redirect_i = 1'b0;
    logic [31:0]   redirect_pc_i = '0;
    logic          consume_i = 1'b0;
    logic          consume_comp_i = 1'b0;
    logic [CW-1:0] hw_count_o;
    logic          rd_hw_off_o;
    logic          buf_wr_o;
    logic          buf_clear_o;
    logic          mmu_req_o;
    logic [31:0]   fetch_vaddr_o;
    logic          mmu_hit_i = 1'b0;
    logic          mmu_fault_i = 1'b0;
    logic          icache_req_o;
    logic          icache_ack_i = 1'b0;
    logic          fault_o;

    always #5 clk = ~clk;

    prefetch_ctrl #(
        .FIFO_WORDS (FW),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .consume_i      (consume_i),
        .consume_comp_i (consume_comp_i),
        .hw_count_o     (hw_count_o),
        .rd_hw_off_o    (rd_hw_off_o),
        .buf_wr_o       (buf_wr_o),
        .buf_clear_o    (buf_clear_o),
        .mmu_req_o      (mmu_req_o),
        .fetch_vaddr_o  (fetch_vaddr_o),
        .mmu_hit_i      (mmu_hit_i),
        .mmu_fault_i    (mmu_fault_i),
        .icache_req_o   (icache_req_o),
        .icache_ack_i   (icache_ack_i),
        .fault_o        (fault_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          count;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] m_addr;
    int          m_count;
    logic        m_off;
    logic        m_skip;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_addr  = 32'h8000_0000;
        m_count = 0;
        m_off   = 1'b0;
        m_skip  = 1'b0;
    endtask

    task automatic wait_mmu();
        for (int i = 0; i < 20 && mmu_req_o !== 1'b1; i++) step();
        n_checks++;
        if (mmu_req_o !== 1'b1) $display("FAIL mmu_req_timeout: got %b want 1", mmu_req_o);
        else n_pass++;
        n_checks++;
        if (fetch_vaddr_o !== m_addr) $display("FAIL xlate_vaddr: got %h want %h", fetch_vaddr_o, m_addr);
        else n_pass++;
    endtask

    // cons: 0 none, 1 compressed, 2 full-width consume in the ack cycle
    task automatic fetch_word(input int ack_wait, input int cons);
        exp_t e;
        int   amt;
        logic legal;
        wait_mmu();
        mmu_hit_i = 1'b1;
        #1;
        n_checks++;
        if (icache_req_o !== 1'b1) $display("FAIL xlate_icache_req: got %b want 1", icache_req_o);
        else n_pass++;
        step();
        mmu_hit_i = 1'b0;
        repeat (ack_wait) begin
            n_checks++;
            if (icache_req_o !== 1'b1 || buf_wr_o !== 1'b0)
                $display("FAIL cache_wait: req=%b wr=%b want req=1 wr=0", icache_req_o, buf_wr_o);
            else n_pass++;
            step();
        end
        amt   = (cons == 1) ? 1 : 2;
        legal = (cons != 0) && (m_count >= amt);
        e.addr  = m_addr;
        e.count = m_count + (m_skip ? 1 : 2) - (legal ? amt : 0);
        sb_q.push_back(e);
        icache_ack_i   = 1'b1;
        consume_i      = (cons != 0);
        consume_comp_i = (cons == 1);
        #1;
        n_checks++;
        if (buf_wr_o === 1'b1 && sb_q.size() > 0) begin
            n_pass++;
            e = sb_q.pop_front();
            n_checks++;
            if (fetch_vaddr_o !== e.addr) $display("FAIL push_addr: got %h want %h", fetch_vaddr_o, e.addr);
            else n_pass++;
            step();
            icache_ack_i = 1'b0;
            consume_i    = 1'b0;
            n_checks++;
            if (hw_count_o !== CW'(e.count)) $display("FAIL push_count: got %0d want %0d", hw_count_o, e.count);
            else n_pass++;
            n_checks++;
            if (fetch_vaddr_o !== e.addr + 32'd4) $display("FAIL next_vaddr: got %h want %h", fetch_vaddr_o, e.addr + 32'd4);
            else n_pass++;
            $display("push addr=%h count=%0d off=%b", e.addr, hw_count_o, rd_hw_off_o);
        end else begin
            $display("FAIL buf_wr: got %b want 1", buf_wr_o);
            sb_q.delete();
            step();
            icache_ack_i = 1'b0;
            consume_i    = 1'b0;
        end
        m_addr  = m_addr + 32'd4;
        m_count = e.count;
        m_skip  = 1'b0;
        if (legal && cons == 1) m_off = ~m_off;
    endtask

    task automatic do_consume(input logic comp);
        int amt;
        amt = comp ? 1 : 2;
        consume_i      = 1'b1;
        consume_comp_i = comp;
        step();
        consume_i = 1'b0;
        if (m_count >= amt) begin
            m_count = m_count - amt;
            if (comp) m_off = ~m_off;
        end
        n_checks++;
        if (hw_count_o !== CW'(m_count) || rd_hw_off_o !== m_off)
            $display("FAIL consume: count=%0d off=%b want count=%0d off=%b", hw_count_o, rd_hw_off_o, m_count, m_off);
        else n_pass++;
        $display("consume comp=%b count=%0d off=%b", comp, hw_count_o, rd_hw_off_o);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        #1;
        n_checks++;
        if (buf_clear_o !== 1'b1 || buf_wr_o !== 1'b0)
            $display("FAIL redirect_cycle: clear=%b wr=%b want clear=1 wr=0", buf_clear_o, buf_wr_o);
        else n_pass++;
        step();
        redirect_i   = 1'b0;
        icache_ack_i = 1'b0;
        m_addr  = {pc[31:2], 2'b00};
        m_count = 0;
        m_off   = pc[1];
        m_skip  = pc[1];
        n_checks++;
        if (hw_count_o !== '0 || fetch_vaddr_o !== m_addr || rd_hw_off_o !== m_off)
            $display("FAIL redirect_state: count=%0d vaddr=%h off=%b want 0 %h %b",
                     hw_count_o, fetch_vaddr_o, rd_hw_off_o, m_addr, m_off);
        else n_pass++;
        $display("redirect pc=%h vaddr=%h off=%b", pc, fetch_vaddr_o, rd_hw_off_o);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (hw_count_o !== '0 || fetch_vaddr_o !== 32'h8000_0000 || rd_hw_off_o !== 1'b0)
            $display("FAIL reset_state: count=%0d vaddr=%h off=%b", hw_count_o, fetch_vaddr_o, rd_hw_off_o);
        else n_pass++;
        n_checks++;
        if ({mmu_req_o, icache_req_o, buf_wr_o, buf_clear_o, fault_o} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000",
                     {mmu_req_o, icache_req_o, buf_wr_o, buf_clear_o, fault_o});
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_fill_and_stall();
        logic stalled;
        fetch_word(1, 0);
        fetch_word(0, 0);
        stalled = 1'b1;
        repeat (6) begin
            step();
            if (mmu_req_o !== 1'b0 || hw_count_o !== CW'(4)) stalled = 1'b0;
        end
        n_checks++;
        if (!stalled) $display("FAIL full_stall: mmu_req=%b count=%0d want 0 4", mmu_req_o, hw_count_o);
        else n_pass++;
    endtask

    task automatic test_misaligned_redirect();
        do_redirect(32'h8000_0102);
        fetch_word(0, 0);
        do_consume(1'b1);
    endtask

    task automatic test_redirect_in_cache();
        wait_mmu();
        mmu_hit_i = 1'b1;
        step();
        mmu_hit_i = 1'b0;
        do_redirect(32'h8000_0200);
        n_checks++;
        if (icache_req_o !== 1'b1 || mmu_req_o !== 1'b0)
            $display("FAIL drain_req: icache=%b mmu=%b want 1 0", icache_req_o, mmu_req_o);
        else n_pass++;
        step();
        icache_ack_i = 1'b1;
        #1;
        n_checks++;
        if (buf_wr_o !== 1'b0) $display("FAIL drain_discard: got %b want 0", buf_wr_o);
        else n_pass++;
        step();
        icache_ack_i = 1'b0;
        n_checks++;
        if (hw_count_o !== '0) $display("FAIL drain_count: got %0d want 0", hw_count_o);
        else n_pass++;
        wait_mmu();
        mmu_hit_i = 1'b1;
        step();
        mmu_hit_i = 1'b0;
        icache_ack_i = 1'b1;
        do_redirect(32'h8000_0300);
        wait_mmu();
    endtask

    task automatic test_push_consume();
        fetch_word(0, 0);
        fetch_word(0, 2);
        do_consume(1'b1);
        do_consume(1'b0);
    endtask

    task automatic test_fault();
        fetch_word(0, 0);
        do_consume(1'b1);
        wait_mmu();
        mmu_fault_i = 1'b1;
        mmu_hit_i   = 1'b1;
        #1;
        n_checks++;
        if (icache_req_o !== 1'b0) $display("FAIL fault_beats_hit: icache_req=%b want 0", icache_req_o);
        else n_pass++;
        step();
        mmu_fault_i = 1'b0;
        mmu_hit_i   = 1'b0;
        n_checks++;
        if (fault_o !== 1'b1 || mmu_req_o !== 1'b0)
            $display("FAIL fault_state: fault=%b mmu_req=%b want 1 0", fault_o, mmu_req_o);
        else n_pass++;
        do_consume(1'b0);
        n_checks++;
        if (fault_o !== 1'b1) $display("FAIL fault_hold: got %b want 1", fault_o);
        else n_pass++;
        do_redirect(32'h8000_0400);
        n_checks++;
        if (fault_o !== 1'b0) $display("FAIL fault_exit: got %b want 0", fault_o);
        else n_pass++;
        fetch_word(0, 0);
    endtask

    task automatic test_wrap();
        do_redirect(32'hFFFF_FFFE);
        fetch_word(0, 0);
    endtask

    task automatic test_async_reset();
        wait_mmu();
        mmu_hit_i = 1'b1;
        step();
        mmu_hit_i = 1'b0;
        n_checks++;
        if (icache_req_o !== 1'b1) $display("FAIL cache_precond: got %b want 1", icache_req_o);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (hw_count_o !== '0 || fetch_vaddr_o !== 32'h8000_0000 || rd_hw_off_o !== 1'b0 ||
            {mmu_req_o, icache_req_o, buf_wr_o, buf_clear_o, fault_o} !== 5'b0)
            $display("FAIL async_reset: count=%0d vaddr=%h off=%b outs=%b", hw_count_o, fetch_vaddr_o,
                     rd_hw_off_o, {mmu_req_o, icache_req_o, buf_wr_o, buf_clear_o, fault_o});
        else n_pass++;
        step();
        reset = 1'b0;
        model_reset();
        fetch_word(0, 0);
    endtask

    initial begin
        test_reset();
        test_fill_and_stall();
        test_misaligned_redirect();
        test_redirect_in_cache();
        test_push_consume();
        test_fault();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
